// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its decode neighbour.
package fetch_stage_pkg;

   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned INSTR_W    = 16;
   localparam int unsigned OPCODE_W   = 4;
   localparam int unsigned OPCODE_MSB = INSTR_W - 1;

   // Opcode map shared with unidad_control
   localparam logic [OPCODE_W-1:0] OP_NOP    = 4'b0000;
   localparam logic [OPCODE_W-1:0] OP_ADD    = 4'b0001;
   localparam logic [OPCODE_W-1:0] OP_SUB    = 4'b0010;
   localparam logic [OPCODE_W-1:0] OP_MUL    = 4'b0011;
   localparam logic [OPCODE_W-1:0] OP_AND    = 4'b0100;
   localparam logic [OPCODE_W-1:0] OP_OR     = 4'b0101;
   localparam logic [OPCODE_W-1:0] OP_XOR    = 4'b0110;
   localparam logic [OPCODE_W-1:0] OP_SHL    = 4'b0111;
   localparam logic [OPCODE_W-1:0] OP_SHR    = 4'b1000;
   localparam logic [OPCODE_W-1:0] OP_LD     = 4'b1001;
   localparam logic [OPCODE_W-1:0] OP_ST     = 4'b1010;
   localparam logic [OPCODE_W-1:0] OP_VADD   = 4'b1011;
   localparam logic [OPCODE_W-1:0] OP_VSUB   = 4'b1100;
   localparam logic [OPCODE_W-1:0] OP_VMUL   = 4'b1101;
   localparam logic [OPCODE_W-1:0] OP_LD_VEC = 4'b1110;
   localparam logic [OPCODE_W-1:0] OP_ST_SUM = 4'b1111;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds on stall, drops the valid bit on flush or halt.
module if_id_reg #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic               clear,
   input  logic [INSTR_W-1:0] instr_d,
   input  logic [ADDR_W-1:0]  pc_d,
   input  logic               valid_d,
   output logic [INSTR_W-1:0] instr_q,
   output logic [ADDR_W-1:0]  pc_q,
   output logic               valid_q
);

   // clear outranks hold so a redirect can flush a stalled stage
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (!hold) begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction memory
// and feeds the IF/ID register whose opcode goes to unidad_control.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INSTR_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                sel_pc,
   input  logic                br_taken,
   input  logic [ADDR_W-1:0]   br_target,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic                imem_en,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  instr_out,
   output logic [OPCODE_W-1:0] opcode_out,
   output logic [ADDR_W-1:0]   pc_out,
   output logic                valid_out
);

   localparam int unsigned OP_MSB = INSTR_W - 1;

   logic [ADDR_W-1:0] pc_q;
   logic              req_v;
   logic [ADDR_W-1:0] req_pc;
   fetch_state_e      state_q;

   logic              halt_c;
   logic              if_id_hold_c;
   logic              if_id_clear_c;

   // sel_pc only counts against a live instruction; bubbles decode as halt by default
   assign halt_c = (state_q == RUN) & valid_out & sel_pc & ~stall & ~br_taken;

   assign if_id_hold_c  = stall | (state_q == HALT);
   assign if_id_clear_c = br_taken | halt_c;

   assign imem_addr = pc_q;
   assign imem_en   = (state_q == RUN) & ~stall & ~rst;

   // PC, in-flight request tracking and RUN/HALT control
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         req_v   <= 1'b0;
         req_pc  <= '0;
         state_q <= RUN;
      end else if (br_taken) begin
         pc_q    <= br_target;
         req_v   <= 1'b0;
         state_q <= RUN;
      end else if (stall) begin
         pc_q    <= pc_q;
         req_v   <= req_v;
         req_pc  <= req_pc;
         state_q <= state_q;
      end else if (halt_c) begin
         req_v   <= 1'b0;
         state_q <= HALT;
      end else if (state_q == RUN) begin
         req_v  <= 1'b1;
         req_pc <= pc_q;
         pc_q   <= pc_q + ADDR_W'(1);
      end
   end

   if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .hold    (if_id_hold_c),
      .clear   (if_id_clear_c),
      .instr_d (imem_rdata),
      .pc_d    (req_pc),
      .valid_d (req_v),
      .instr_q (instr_out),
      .pc_q    (pc_out),
      .valid_q (valid_out)
   );

   assign opcode_out = instr_out[OP_MSB -: OPCODE_W];

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous instruction memory model
// and a stand-in decode that raises sel_pc on bubbles and on opcode 1111.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        sel_pc;
   logic        br_taken;
   logic [7:0]  br_target;
   logic [7:0]  imem_addr;
   logic        imem_en;
   logic [15:0] imem_rdata = '0;
   logic [15:0] instr_out;
   logic [3:0]  opcode_out;
   logic [7:0]  pc_out;
   logic        valid_out;

   logic [15:0] mem [256];
   int          vectors    = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

   // default decode: a bubble decodes as halt; opcode 1111 halts
   assign sel_pc = ~valid_out | (opcode_out == 4'hF);

   fetch_stage #(.ADDR_W(8), .INSTR_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .sel_pc     (sel_pc),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_addr  (imem_addr),
      .imem_en    (imem_en),
      .imem_rdata (imem_rdata),
      .instr_out  (instr_out),
      .opcode_out (opcode_out),
      .pc_out     (pc_out),
      .valid_out  (valid_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
      tick();
      tick();
      vectors++;
      if ({valid_out, pc_out, instr_out, imem_addr, imem_en} !== {1'b0, 8'h00, 16'h0000, 8'h00, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got v=%0b pc=%h instr=%h addr=%h en=%0b want v=0 pc=00 instr=0000 addr=00 en=0",
                  valid_out, pc_out, instr_out, imem_addr, imem_en);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (imem_en !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_en: got en=%0b want 1", imem_en);
      end
   endtask

   task automatic test_startup();
      logic [24:0] exp [3] = '{{1'b1, 8'h00, 16'h1000}, {1'b1, 8'h01, 16'h2000}, {1'b1, 8'h02, 16'h3000}};
      do_reset();
      tick();
      vectors++;
      if ({valid_out, imem_addr} !== {1'b0, 8'h01}) begin
         miscompares++;
         $display("FAIL startup_edge1: got v=%0b addr=%h want v=0 addr=01", valid_out, imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({valid_out, pc_out, instr_out} !== exp[i]) begin
            miscompares++;
            $display("FAIL startup_edge%0d: got v=%0b pc=%h instr=%h want %h", i + 2, valid_out, pc_out, instr_out, exp[i]);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick(); tick(); tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if ({valid_out, pc_out, imem_addr, imem_en} !== {1'b1, 8'h01, 8'h03, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got v=%0b pc=%h addr=%h en=%0b want v=1 pc=01 addr=03 en=0",
                     i, valid_out, pc_out, imem_addr, imem_en);
         end
         tick();
      end
      stall = 1'b0;
      tick();
      vectors++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 8'h02, 16'h3000}) begin
         miscompares++;
         $display("FAIL stall_release_pc2: got v=%0b pc=%h instr=%h want v=1 pc=02 instr=3000", valid_out, pc_out, instr_out);
      end
      tick();
      vectors++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 8'h03, 16'h4000}) begin
         miscompares++;
         $display("FAIL stall_release_pc3: got v=%0b pc=%h instr=%h want v=1 pc=03 instr=4000", valid_out, pc_out, instr_out);
      end
   endtask

   task automatic test_branch_in_stall();
      do_reset();
      tick(); tick(); tick();
      stall = 1'b1;
      tick();
      br_taken = 1'b1; br_target = 8'h40;
      tick();
      br_taken = 1'b0; stall = 1'b0;
      vectors++;
      if ({valid_out, imem_addr} !== {1'b0, 8'h40}) begin
         miscompares++;
         $display("FAIL branch_flush: got v=%0b addr=%h want v=0 addr=40", valid_out, imem_addr);
      end
      tick();
      vectors++;
      if ({valid_out, imem_addr} !== {1'b0, 8'h41}) begin
         miscompares++;
         $display("FAIL branch_issue: got v=%0b addr=%h want v=0 addr=41", valid_out, imem_addr);
      end
      tick();
      vectors++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 8'h40, 16'h2040}) begin
         miscompares++;
         $display("FAIL branch_target: got v=%0b pc=%h instr=%h want v=1 pc=40 instr=2040", valid_out, pc_out, instr_out);
      end
      tick();
      vectors++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 8'h41, 16'h2041}) begin
         miscompares++;
         $display("FAIL branch_next: got v=%0b pc=%h instr=%h want v=1 pc=41 instr=2041", valid_out, pc_out, instr_out);
      end
   endtask

   task automatic test_halt();
      do_reset();
      for (int n = 1; n <= 7; n++) begin
         tick();
         if (n >= 2) begin
            vectors++;
            if ({valid_out, pc_out} !== {1'b1, 8'(n - 2)}) begin
               miscompares++;
               $display("FAIL halt_run_edge%0d: got v=%0b pc=%h want v=1 pc=%h", n, valid_out, pc_out, 8'(n - 2));
            end
         end
      end
      vectors++;
      if (opcode_out !== 4'hF) begin
         miscompares++;
         $display("FAIL halt_opcode: got %h want f", opcode_out);
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         vectors++;
         if ({valid_out, imem_en, imem_addr} !== {1'b0, 1'b0, 8'h07}) begin
            miscompares++;
            $display("FAIL halt_hold%0d: got v=%0b en=%0b addr=%h want v=0 en=0 addr=07", k, valid_out, imem_en, imem_addr);
         end
      end
      br_taken = 1'b1; br_target = 8'h00;
      tick();
      br_taken = 1'b0;
      vectors++;
      if ({valid_out, imem_en, imem_addr} !== {1'b0, 1'b1, 8'h00}) begin
         miscompares++;
         $display("FAIL halt_resume: got v=%0b en=%0b addr=%h want v=0 en=1 addr=00", valid_out, imem_en, imem_addr);
      end
      tick();
      tick();
      vectors++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 8'h00, 16'h1000}) begin
         miscompares++;
         $display("FAIL halt_resume_pc0: got v=%0b pc=%h instr=%h want v=1 pc=00 instr=1000", valid_out, pc_out, instr_out);
      end
   endtask

   task automatic test_wrap();
      logic [24:0] exp [4] = '{{1'b1, 8'hFE, 16'h20FE}, {1'b1, 8'hFF, 16'h20FF},
                               {1'b1, 8'h00, 16'h1000}, {1'b1, 8'h01, 16'h2000}};
      do_reset();
      br_taken = 1'b1; br_target = 8'hFE;
      tick();
      br_taken = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if ({valid_out, pc_out, instr_out} !== exp[i]) begin
            miscompares++;
            $display("FAIL wrap_%0d: got v=%0b pc=%h instr=%h want %h", i, valid_out, pc_out, instr_out, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (imem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_en: got en=%0b want 0", imem_en);
      end
      tick();
      rst = 1'b0;
      vectors++;
      if ({valid_out, imem_addr, pc_out, instr_out} !== {1'b0, 8'h00, 8'h00, 16'h0000}) begin
         miscompares++;
         $display("FAIL midrst_clear: got v=%0b addr=%h pc=%h instr=%h want v=0 addr=00 pc=00 instr=0000",
                  valid_out, imem_addr, pc_out, instr_out);
      end
      tick();
      vectors++;
      if (valid_out !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_no_stale: got v=%0b pc=%h instr=%h want v=0", valid_out, pc_out, instr_out);
      end
      tick();
      vectors++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 8'h00, 16'h1000}) begin
         miscompares++;
         $display("FAIL midrst_restart: got v=%0b pc=%h instr=%h want v=1 pc=00 instr=1000", valid_out, pc_out, instr_out);
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = {8'h20, 8'(a)};
      mem[0] = 16'h1000;
      mem[1] = 16'h2000;
      mem[2] = 16'h3000;
      mem[3] = 16'h4000;
      mem[4] = 16'h5000;
      mem[5] = 16'hF005;
      mem[6] = 16'h6000;
      rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;

      test_reset();
      test_startup();
      test_stall();
      test_branch_in_stall();
      test_halt();
      test_wrap();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_fetch_stage
